// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if
//   Issue-side and writeback-side handshake bundle for alu_exec_unit.
//   master : the issue/writeback environment (drives operands and out_ready)
//   slave  : the execution unit (drives in_ready, result, status, ops_done)
//   Signals:
//     in_valid / in_ready      operand bundle handshake
//     operation, src_a, src_b  operand bundle
//     out_valid / out_ready    result handshake
//     result, zero, illegal    result bundle
//     ops_done                 completed output handshake count
interface alu_exec_unit_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       operation;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic [CNT_W-1:0] ops_done;

  modport master (
    output in_valid, operation, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal, ops_done
  );

  modport slave (
    input  in_valid, operation, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, illegal, ops_done
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Two-stage execution pipeline for the 4-bit ALU operation code.
//   S1 captures operands and op; S2 computes and holds the result.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      alu_exec_unit_if.slave (operand/result handshakes, status, counter)
//
//   Stage state table (same encoding for S1 and S2)
//   state | meaning
//   EMPTY | stage holds no bundle
//   FULL  | stage holds a bundle waiting to advance
module alu_exec_unit #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_exec_unit_if.slave bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stage_t;

  stage_t s1_state_q, s1_state_d;
  stage_t s2_state_q, s2_state_d;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, illegal_q;
  logic [CNT_W-1:0] ops_done_q;

  logic             s1_full, s2_full;
  logic             s2_load, in_fire, out_fire, in_ready;
  logic [WIDTH-1:0] alu_res;
  logic             alu_illegal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_state_q <= EMPTY;
      s2_state_q <= EMPTY;
    end else begin
      s1_state_q <= s1_state_d;
      s2_state_q <= s2_state_d;
    end
  end

  always_comb begin
    s1_full     = (s1_state_q == FULL);
    s2_full     = (s2_state_q == FULL);
    // S2 takes the S1 bundle when it is empty or its result leaves this cycle.
    s2_load     = s1_full && (!s2_full || bus.out_ready);
    in_ready    = !s1_full || s2_load;
    in_fire     = bus.in_valid && in_ready;
    out_fire    = s2_full && bus.out_ready;
    s1_state_d  = s1_state_q;
    s2_state_d  = s2_state_q;

    if (in_fire)       s1_state_d = FULL;
    else if (s2_load)  s1_state_d = EMPTY;

    if (s2_load)       s2_state_d = FULL;
    else if (out_fire) s2_state_d = EMPTY;
  end

  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (op_q)
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      default: alu_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (in_fire) begin
        op_q <= bus.operation;
        a_q  <= bus.src_a;
        b_q  <= bus.src_b;
      end
      if (s2_load) begin
        result_q  <= alu_res;
        zero_q    <= (alu_res == '0);
        illegal_q <= alu_illegal;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      ops_done_q <= '0;
    else if (out_fire) ops_done_q <= ops_done_q + 1'b1;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_full;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
  assign bus.ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  localparam int WIDTH = 64;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) ifc ();

  alu_exec_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  typedef struct {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             z;
    logic             il;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             il;
  } exp_t;

  int n_chk  = 0;
  int n_fail = 0;
  exp_t exp_q[$];
  int model_cnt = 0;
  logic last_fire = 1'b0;
  logic stall_q = 1'b0;
  logic [WIDTH-1:0] held_res;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the architectural meaning of each op code.
  function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    e.il = 1'b0;
    case (op)
      4'd0:    e.res = a & b;
      4'd1:    e.res = a | b;
      4'd2:    e.res = a + b;
      4'd6:    e.res = a - b;
      default: begin e.res = '0; e.il = 1'b1; end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  function automatic logic [3:0] rand_op();
    int p = $urandom_range(0, 9);
    if (p < 2) return 4'd0;
    if (p < 4) return 4'd1;
    if (p < 6) return 4'd2;
    if (p < 8) return 4'd6;
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic new_bundle();
    ifc.operation = rand_op();
    ifc.src_a = {$urandom, $urandom};
    ifc.src_b = ($urandom_range(0, 7) == 0) ? ifc.src_a : {$urandom, $urandom};
  endtask

  // One cycle: inputs already set at the negedge; observe the handshakes
  // that fire at the coming posedge, then land on the next negedge.
  task automatic step();
    logic fire_in, fire_out;
    exp_t e;
    #1;
    if (stall_q) begin
      chk("hold_valid", {63'd0, ifc.out_valid}, 64'd1);
      chk("hold_result", ifc.result, held_res);
    end
    fire_in  = ifc.in_valid && ifc.in_ready;
    fire_out = ifc.out_valid && ifc.out_ready;
    stall_q  = ifc.out_valid && !ifc.out_ready;
    held_res = ifc.result;
    if (fire_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {63'd0, ifc.out_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", ifc.result, e.res);
        chk("sb_zero", {63'd0, ifc.zero}, {63'd0, e.z});
        chk("sb_illegal", {63'd0, ifc.illegal}, {63'd0, e.il});
      end
    end
    if (fire_in) exp_q.push_back(model(ifc.operation, ifc.src_a, ifc.src_b));
    last_fire = fire_in;
    @(posedge clk);
    if (fire_out) model_cnt++;
    @(negedge clk);
    chk("ops_done", {48'd0, ifc.ops_done}, 64'(model_cnt));
  endtask

  task automatic drain();
    int k;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || ifc.out_valid) && k < 10) begin
      step();
      k++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_out_valid", {63'd0, ifc.out_valid}, 64'd0);
  endtask

  vec_t vt[8];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int k;
    vt[0] = '{4'b0000, 64'd12, 64'd10, 64'd8,  1'b0, 1'b0};
    vt[1] = '{4'b0001, 64'd12, 64'd10, 64'd14, 1'b0, 1'b0};
    vt[2] = '{4'b0010, 64'd12, 64'd10, 64'd22, 1'b0, 1'b0};
    vt[3] = '{4'b0110, 64'd12, 64'd10, 64'd2,  1'b0, 1'b0};
    vt[4] = '{4'b0010, '1,     64'd1,  64'd0,  1'b1, 1'b0};
    vt[5] = '{4'b0110, 64'd0,  64'd1,  '1,     1'b0, 1'b0};
    vt[6] = '{4'b1111, 64'd5,  64'd3,  64'd0,  1'b1, 1'b1};
    vt[7] = '{4'b0001, 64'd5,  64'd3,  64'd7,  1'b0, 1'b0};

    ifc.in_valid  = 1'b0;
    ifc.operation = 4'd0;
    ifc.src_a     = '0;
    ifc.src_b     = '0;
    ifc.out_ready = 1'b1;

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    chk("rst_ops_done", {48'd0, ifc.ops_done}, 64'd0);
    chk("rst_result", ifc.result, 64'd0);
    chk("rst_zero", {63'd0, ifc.zero}, 64'd0);
    chk("rst_illegal", {63'd0, ifc.illegal}, 64'd0);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", {63'd0, ifc.in_ready}, 64'd1);
    @(negedge clk);

    // Directed vectors with explicit latency check
    for (int i = 0; i < 8; i++) begin
      ifc.operation = vt[i].op;
      ifc.src_a     = vt[i].a;
      ifc.src_b     = vt[i].b;
      ifc.in_valid  = 1'b1;
      #1;
      chk("vec_in_ready", {63'd0, ifc.in_ready}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      ifc.in_valid = 1'b0;
      #1;
      chk("vec_lat1_invalid", {63'd0, ifc.out_valid}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("vec_lat2_valid", {63'd0, ifc.out_valid}, 64'd1);
      chk("vec_result", ifc.result, vt[i].res);
      chk("vec_zero", {63'd0, ifc.zero}, {63'd0, vt[i].z});
      chk("vec_illegal", {63'd0, ifc.illegal}, {63'd0, vt[i].il});
      model_cnt++;
      @(posedge clk);
      @(negedge clk);
      chk("vec_ops_done", {48'd0, ifc.ops_done}, 64'(model_cnt));
    end

    // Backpressure: three bundles with out_ready low
    ifc.out_ready = 1'b0;
    acc = 0;
    for (int j = 0; j < 2; j++) begin
      new_bundle();
      ifc.in_valid = 1'b1;
      step();
      if (last_fire) acc++;
    end
    chk("bp_accepted", 64'(acc), 64'd2);
    new_bundle();
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("bp_in_ready_low", {63'd0, ifc.in_ready}, 64'd0);
      step();
    end
    ifc.out_ready = 1'b1;
    k = 0;
    while (ifc.in_valid && k < 5) begin
      step();
      if (last_fire) ifc.in_valid = 1'b0;
      k++;
    end
    chk("bp_third_accepted", {63'd0, ifc.in_valid}, 64'd0);
    drain();
    chk("bp_ops_done", {48'd0, ifc.ops_done}, 64'd11);

    // 100 back-to-back random ops at full throughput
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      new_bundle();
      ifc.in_valid = 1'b1;
      step();
      chk("stream_accept", {63'd0, last_fire}, 64'd1);
      if (i >= 1) chk("stream_out_valid", {63'd0, ifc.out_valid}, 64'd1);
    end
    drain();

    // Random handshakes on both sides, input held until accepted
    ifc.in_valid = 1'b0;
    last_fire = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!ifc.in_valid || last_fire) begin
        new_bundle();
        ifc.in_valid = ($urandom_range(0, 3) != 0);
      end
      ifc.out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drain();

    // Reset mid-stream
    for (int i = 0; i < 10; i++) begin
      new_bundle();
      ifc.in_valid = 1'b1;
      step();
    end
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    chk("mid_rst_ops_done", {48'd0, ifc.ops_done}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, ifc.in_ready}, 64'd1);
    exp_q.delete();
    model_cnt = 0;
    stall_q = 1'b0;
    ifc.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_hold_valid", {63'd0, ifc.out_valid}, 64'd0);
    reset_n = 1'b1;
    step();
    chk("post_rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      new_bundle();
      ifc.in_valid = 1'b1;
      step();
    end
    drain();
    chk("post_rst_ops_done", {48'd0, ifc.ops_done}, 64'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
